cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised writeback stage between the N functional units and the M common data buses.
- Each FU output is buffered in a per-FU FIFO with valid/ready backpressure.
- Up to NUM_CDB results are granted per cycle by a rotating round-robin arbiter, and the grants drive registered CDB ports.
- A flush empties all in-flight results.

Parameters:
- NUM_FU, 3: number of functional-unit producers. Index 0=ALU, 1=MUL, 2=DIV by convention.
- NUM_CDB, 2: number of CDB broadcast ports. Must satisfy 1 <= NUM_CDB <= NUM_FU; elaboration error otherwise.
- QDEPTH, 2: entries per FU FIFO. Must be a power of 2 and >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- flush  in  1  squash every buffered result and the CDB output registers.
- fu_valid  in  [NUM_FU]  FU presents a result.
- fu_data  in  [NUM_FU] x $bits(execution_out_t)  FU result payload.
- fu_ready  out  [NUM_FU]  FIFO can accept a result this cycle.
- cdb_valid  out  [NUM_CDB]  broadcast valid.
- cdb_data  out  [NUM_CDB] x $bits(CDB_t)  broadcast payload.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs empty, all counts 0.
  - rr_ptr=0.
  - cdb_valid=0 and cdb_data='0.
  - fu_ready=all-ones immediately after reset deassertion.
- Reset asserted mid-operation: all state is cleared at once; in-flight results are lost.
- Enqueue:
  - Occurs at an edge where fu_valid[i] && fu_ready[i].
  - fu_ready[i] = (count[i] != QDEPTH), taken from the registered count only. A same-cycle pop does not raise ready when full.
  - fu_valid while not ready: the data is ignored, and the FU must hold it.
- Eligibility: FIFO i is eligible when count[i] != 0; its head is the candidate.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Grant the first NUM_CDB eligible FIFOs.
  - The k-th grant in scan order maps to CDB port k.
  - Unused ports get valid=0.
- Output:
  - At the edge, granted heads are popped.
  - cdb_valid[k] <= 1 and cdb_data[k] <= head converted to CDB_t.
  - For ungranted ports, cdb_valid[k] <= 0 and cdb_data[k] <= '0. Data is always zero when invalid.
- Latency (base): enqueue at edge t, earliest broadcast visible after edge t+1 (2 edges).
- Pointer update:
  - If any grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - If no grant, rr_ptr is unchanged.
  - Starvation-free: every eligible FIFO is granted within ceil(NUM_FU/NUM_CDB) cycles.
- Simultaneous push and pop on the same FIFO: count is unchanged; FIFO order is preserved.
- Pointer wrap: head/tail pointers are log2(QDEPTH) bits and wrap naturally. QDEPTH=1 uses a single entry with a valid bit.
- Flush:
  - At that edge, all counts go to 0, cdb_valid to 0, cdb_data to '0. rr_ptr is unchanged.
  - Flush has priority over a same-cycle enqueue, which is dropped, and over grants (no broadcast).
- Width rule: execution_out_t-to-CDB_t conversion is by field assignment in the package function, not by bit slicing.

Optional Feature:
- Macro CDB_ARB_BYPASS_EN.
- When defined:
  - An FU whose FIFO is empty and which has fu_valid=1 is eligible in the same cycle, using fu_data directly.
  - If granted, the result is broadcast after the next edge (1-edge latency) and is not written to the FIFO.
  - If not granted, it is enqueued normally.
- When undefined: results always traverse the FIFO (2-edge minimum latency).
- Flush still drops a bypass candidate.

Decomposition:
- rv32i_types package holds:
  - execution_out_t and CDB_t.
  - New function to_cdb(execution_out_t) returning CDB_t.
  - Localparam-free constants CDB_NUM_FU_DEFAULT and CDB_NUM_CDB_DEFAULT.
- Sub-module cdb_fu_fifo (parametrised by QDEPTH; push/pop/flush, head, count), instantiated NUM_FU times via generate.
- The arbiter and output registers stay in cdb_arbiter.

Test Plan:
- Reset: hold rst=0 with fu_valid=3'b111 -> cdb_valid=2'b00 and cdb_data='0. After release, fu_ready=3'b111 and rr_ptr=0.
- Three-way contention: NUM_FU=3, NUM_CDB=2, one result per FU at edge 0 -> FU0 and FU1 broadcast on ports 0/1 after edge 1; FU2 on port 0 after edge 2; rr_ptr=0 afterward.
- Backpressure: QDEPTH=2, FU1 pushes every cycle while only FU0/FU2 are perpetually eligible ahead of it -> fu_ready[1]=0 after 2 pushes. Held data is accepted once ready rises; results appear in push order (payload tags 0x11, 0x22, 0x33).
- Flush: flush=1 with 4 buffered results and fu_valid[0]=1 -> next cycle all counts are 0 and cdb_valid=0; the enqueued tag never appears on any CDB.
- Fairness: all FUs continuously valid for 30 cycles -> each FU receives exactly 20 grants, and no FU waits more than 2 cycles.
- Bypass (CDB_ARB_BYPASS_EN): empty FIFOs with a single fu_valid[2]=1 (tag 0x5A) at cycle t -> cdb_valid[0]=1 with tag 0x5A after edge t+1; count[2] stays 0. Without the macro, the same stimulus appears after edge t+2.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the writeback stage.
// Holds the functional-unit result record, the common-data-bus record,
// the conversion between them and the default arbiter sizing constants.
package rv32i_types;

  parameter int CDB_NUM_FU_DEFAULT  = 3;
  parameter int CDB_NUM_CDB_DEFAULT = 2;

  // Result leaving a functional unit.
  typedef struct packed {
    logic [7:0]  tag;     // ROB / reservation tag
    logic [4:0]  rd;      // destination architectural register
    logic [31:0] result;  // computed value
    logic        exc;     // exception raised by the unit
  } execution_out_t;

  // Record broadcast on a common data bus.
  typedef struct packed {
    logic [7:0]  tag;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        exc;
  } CDB_t;

  // Field-wise conversion so that layout changes in either record stay safe.
  function automatic CDB_t to_cdb(input execution_out_t eo);
    CDB_t c;
    c       = '0;
    c.tag   = eo.tag;
    c.rd    = eo.rd;
    c.value = eo.result;
    c.exc   = eo.exc;
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of FU-side handshake and CDB broadcast signals of the writeback stage.
// master: the producer/consumer side (FUs and CDB listeners).
// slave : the arbiter itself.
interface cdb_arbiter_if
  import rv32i_types::*;
#(
  parameter int NUM_FU  = CDB_NUM_FU_DEFAULT,
  parameter int NUM_CDB = CDB_NUM_CDB_DEFAULT
) ();

  logic           [NUM_FU-1:0]  fu_valid;
  execution_out_t [NUM_FU-1:0]  fu_data;
  logic           [NUM_FU-1:0]  fu_ready;
  logic           [NUM_CDB-1:0] cdb_valid;
  CDB_t           [NUM_CDB-1:0] cdb_data;

  modport master (
    output fu_valid,
    output fu_data,
    input  fu_ready,
    input  cdb_valid,
    input  cdb_data
  );

  modport slave (
    input  fu_valid,
    input  fu_data,
    output fu_ready,
    output cdb_valid,
    output cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_fu_fifo.sv
// Per-FU result buffer of the writeback stage (module cdb_fu_fifo).
// Push/pop/flush interface, head-of-queue output and a registered occupancy
// count. Pointers are log2(QDEPTH) bits and wrap naturally; a depth of one
// degenerates to a single entry guarded by a valid bit. The caller never
// pushes when full nor pops when empty.
module cdb_fu_fifo
  import rv32i_types::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           push,
  input  execution_out_t push_data,
  input  logic           pop,
  output execution_out_t head,
  output logic [CW-1:0]  count
);

  if (QDEPTH == 1) begin : g_single

    logic           valid_r;
    execution_out_t entry_r;

    // Single-entry storage: fill on push, release on pop, clear on flush.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_r <= 1'b0;
        entry_r <= '0;
      end else if (flush) begin
        valid_r <= 1'b0;
        entry_r <= '0;
      end else if (push) begin
        valid_r <= 1'b1;
        entry_r <= push_data;
      end else if (pop) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    assign head  = entry_r;
    assign count = CW'(valid_r);

  end else begin : g_ring

    localparam int PW = $clog2(QDEPTH);

    execution_out_t mem_r [QDEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    // Ring buffer: write at tail, read at head; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int e = 0; e < QDEPTH; e++) begin
          mem_r[e] <= '0;
        end
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push) begin
          mem_r[wr_ptr_r] <= push_data;
          wr_ptr_r        <= wr_ptr_r + PW'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push, pop})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback stage: buffers NUM_FU functional-unit results in per-FU FIFOs
// and grants up to NUM_CDB of them per cycle to registered CDB ports using
// a rotating round-robin scan starting at rr_ptr. The k-th grant in scan
// order drives CDB port k. flush squashes all buffered results and the
// output registers but keeps the round-robin pointer.
// Optional feature macro: CDB_ARB_BYPASS_EN -- an FU with an empty FIFO and
// a valid result competes in the same cycle with fu_data; if granted it is
// broadcast after one edge and never written to its FIFO.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU  = CDB_NUM_FU_DEFAULT,
  parameter int NUM_CDB = CDB_NUM_CDB_DEFAULT,
  parameter int QDEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  cdb_arbiter_if.slave   bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  if ((NUM_CDB < 1) || (NUM_CDB > NUM_FU)) begin : g_bad_num_cdb
    $error("cdb_arbiter: NUM_CDB must satisfy 1 <= NUM_CDB <= NUM_FU");
  end
  if ((QDEPTH < 1) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_qdepth
    $error("cdb_arbiter: QDEPTH must be a power of two and at least 1");
  end

  logic [CW-1:0]        count_s   [NUM_FU];
  execution_out_t       head_s    [NUM_FU];
  execution_out_t       cand_s    [NUM_FU];
  logic [NUM_FU-1:0]    ready_s;
  logic [NUM_FU-1:0]    elig_s;
  logic [NUM_FU-1:0]    byp_s;
  logic [NUM_FU-1:0]    grant_s;
  logic [NUM_FU-1:0]    push_s;
  logic [NUM_FU-1:0]    pop_s;
  logic [RW-1:0]        sel_s     [NUM_CDB];
  logic [NUM_CDB-1:0]   port_vld_s;
  CDB_t [NUM_CDB-1:0]   cdb_data_next_s;
  logic [RW-1:0]        rr_next_s;
  logic [RW-1:0]        rr_ptr_r;
  logic [NUM_CDB-1:0]   cdb_valid_r;
  CDB_t [NUM_CDB-1:0]   cdb_data_r;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_fu_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push_s[g]),
      .push_data (bus.fu_data[g]),
      .pop       (pop_s[g]),
      .head      (head_s[g]),
      .count     (count_s[g])
    );
  end

  // Per-FU readiness (registered count only), eligibility and candidate payload.
  always_comb begin
    ready_s = '0;
    elig_s  = '0;
    byp_s   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand_s[i]  = head_s[i];
      ready_s[i] = (count_s[i] != CW'(QDEPTH));
`ifdef CDB_ARB_BYPASS_EN
      byp_s[i]   = (count_s[i] == '0) && bus.fu_valid[i];
      elig_s[i]  = (count_s[i] != '0) || byp_s[i];
      cand_s[i]  = byp_s[i] ? bus.fu_data[i] : head_s[i];
`else
      elig_s[i]  = (count_s[i] != '0);
`endif
    end
  end

  // Round-robin scan from rr_ptr; first NUM_CDB eligible FUs take ports in order.
  always_comb begin
    int slot;
    int idx;
    slot       = 0;
    idx        = 0;
    grant_s    = '0;
    port_vld_s = '0;
    rr_next_s  = rr_ptr_r;
    for (int k = 0; k < NUM_CDB; k++) begin
      sel_s[k] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(rr_ptr_r) + j;
      idx = (idx >= NUM_FU) ? (idx - NUM_FU) : idx;
      if (elig_s[idx] && (slot < NUM_CDB)) begin
        grant_s[idx]     = 1'b1;
        sel_s[slot]      = RW'(idx);
        port_vld_s[slot] = 1'b1;
        rr_next_s        = RW'((idx + 1) % NUM_FU);
        slot             = slot + 1;
      end else begin
        grant_s[idx] = grant_s[idx];
      end
    end
  end

  // FIFO controls: bypassed grants skip the FIFO; flush blocks both push and pop.
  always_comb begin
    push_s = '0;
    pop_s  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push_s[i] = bus.fu_valid[i] && ready_s[i] && !flush && !(byp_s[i] && grant_s[i]);
      pop_s[i]  = grant_s[i] && !byp_s[i] && !flush;
    end
  end

  // Next CDB payload per port; zero whenever the port is unused.
  always_comb begin
    cdb_data_next_s = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (port_vld_s[k]) begin
        cdb_data_next_s[k] = to_cdb(cand_s[sel_s[k]]);
      end else begin
        cdb_data_next_s[k] = '0;
      end
    end
  end

  // Registered CDB ports, cleared by reset and flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_r <= '0;
      cdb_data_r  <= '0;
    end else if (flush) begin
      cdb_valid_r <= '0;
      cdb_data_r  <= '0;
    end else begin
      cdb_valid_r <= port_vld_s;
      cdb_data_r  <= cdb_data_next_s;
    end
  end

  // Round-robin pointer: moves past the last grant, untouched by flush or idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (flush) begin
      rr_ptr_r <= rr_ptr_r;
    end else begin
      rr_ptr_r <= rr_next_s;
    end
  end

  assign bus.fu_ready  = ready_s;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_data  = cdb_data_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_FU=3, NUM_CDB=2, QDEPTH=2).
// A queue-based reference model predicts every cycle's CDB outputs, fu_ready
// and rr_ptr; directed scenarios add fixed expectations on top.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int NFU  = 3;
  localparam int NCDB = 2;
  localparam int QD   = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NFU), .NUM_CDB(NCDB)) dif ();

  cdb_arbiter #(.NUM_FU(NFU), .NUM_CDB(NCDB), .QDEPTH(QD)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  execution_out_t     mq [NFU][$];
  int                 m_rr   = 0;
  logic [NCDB-1:0]    m_vld  = '0;
  CDB_t [NCDB-1:0]    m_data = '0;
  logic [NFU-1:0]     m_acc  = '0;

  int         grant_cnt [NFU];
  bit         count_grants = 1'b0;
  bit         watch_ee     = 1'b0;
  int         ee_seen      = 0;
  bit         watch_fu1    = 1'b0;
  logic [7:0] fu1_tags [$];
  int         seq = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic CDB_t ref_cdb(input execution_out_t e);
    CDB_t c;
    c.tag   = e.tag;
    c.rd    = e.rd;
    c.value = e.result;
    c.exc   = e.exc;
    return c;
  endfunction

  function automatic logic [NFU-1:0] model_ready();
    logic [NFU-1:0] r;
    for (int i = 0; i < NFU; i++) r[i] = (mq[i].size() < QD);
    return r;
  endfunction

  function automatic logic [7:0] next_tag();
    seq++;
    return 8'(seq);
  endfunction

  task automatic set_fu(input int i, input logic v, input logic [7:0] tg);
    execution_out_t e;
    e.tag    = tg;
    e.rd     = 5'(i);
    e.result = $urandom();
    e.exc    = 1'($urandom_range(0, 1));
    dif.fu_valid[i] = v;
    dif.fu_data[i]  = e;
  endtask

  // Predicts the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    logic [NFU-1:0] rdy;
    logic [NFU-1:0] byp;
    int np;
    int last;
    int idx;
    m_vld  = '0;
    m_data = '0;
    m_acc  = '0;
    if (flush) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
      return;
    end
    rdy  = model_ready();
    byp  = '0;
    np   = 0;
    last = -1;
    for (int j = 0; j < NFU; j++) begin
      idx = (m_rr + j) % NFU;
      if (np < NCDB) begin
        if (mq[idx].size() > 0) begin
          m_data[np] = ref_cdb(mq[idx].pop_front());
          m_vld[np]  = 1'b1;
          np++;
          last = idx;
        end
`ifdef CDB_ARB_BYPASS_EN
        else if (dif.fu_valid[idx]) begin
          m_data[np] = ref_cdb(dif.fu_data[idx]);
          m_vld[np]  = 1'b1;
          np++;
          last = idx;
          byp[idx] = 1'b1;
        end
`endif
      end
    end
    for (int i = 0; i < NFU; i++) begin
      m_acc[i] = dif.fu_valid[i] && rdy[i];
      if (m_acc[i] && !byp[i]) mq[i].push_back(dif.fu_data[i]);
    end
    if (last >= 0) m_rr = (last + 1) % NFU;
  endtask

  // One clock: predict, clock, then compare at the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NCDB; k++) begin
      check_eq($sformatf("cdb_valid[%0d]", k), 64'(dif.cdb_valid[k]), 64'(m_vld[k]));
      check_eq($sformatf("cdb_data[%0d]", k), 64'(dif.cdb_data[k]), 64'(m_data[k]));
      if (dif.cdb_valid[k]) begin
        if (count_grants) grant_cnt[int'(dif.cdb_data[k].rd) % NFU]++;
        if (watch_ee && dif.cdb_data[k].tag == 8'hEE) ee_seen++;
        if (watch_fu1 && dif.cdb_data[k].rd == 5'd1) fu1_tags.push_back(dif.cdb_data[k].tag);
      end
    end
    check_eq("fu_ready", 64'(dif.fu_ready), 64'(model_ready()));
    check_eq("rr_ptr", 64'(dut.rr_ptr_r), 64'(m_rr));
  endtask

  task automatic rand_drive(input int pct);
    for (int i = 0; i < NFU; i++) begin
      if (!(dif.fu_valid[i] && !m_acc[i])) set_fu(i, ($urandom_range(0, 99) < pct), next_tag());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_tags [3];
    int bi;
    bp_tags = '{8'h11, 8'h22, 8'h33};
    dif.fu_valid = '0;
    dif.fu_data  = '0;

    // Reset held with all FUs valid
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, next_tag());
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cdb_valid", 64'(dif.cdb_valid), 64'd0);
    check_eq("rst_cdb_data0", 64'(dif.cdb_data[0]), 64'd0);
    check_eq("rst_cdb_data1", 64'(dif.cdb_data[1]), 64'd0);
    dif.fu_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_fu_ready", 64'(dif.fu_ready), 64'(3'b111));
    check_eq("rst_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);

    // Three-way contention
    set_fu(0, 1'b1, 8'h01);
    set_fu(1, 1'b1, 8'h41);
    set_fu(2, 1'b1, 8'h81);
    tick();
    dif.fu_valid = '0;
    tick();
`ifndef CDB_ARB_BYPASS_EN
    check_eq("cont_e1_valid", 64'(dif.cdb_valid), 64'(2'b11));
    check_eq("cont_e1_tag0", 64'(dif.cdb_data[0].tag), 64'h01);
    check_eq("cont_e1_tag1", 64'(dif.cdb_data[1].tag), 64'h41);
`endif
    tick();
`ifndef CDB_ARB_BYPASS_EN
    check_eq("cont_e2_valid", 64'(dif.cdb_valid), 64'(2'b01));
    check_eq("cont_e2_tag0", 64'(dif.cdb_data[0].tag), 64'h81);
    check_eq("cont_e2_rr", 64'(dut.rr_ptr_r), 64'd0);
`endif
    repeat (2) tick();

    // Backpressure on FU1 with FU0/FU2 always busy
    fu1_tags.delete();
    watch_fu1 = 1'b1;
    bi = 0;
    set_fu(1, 1'b1, bp_tags[0]);
    for (int c = 0; c < 40; c++) begin
      if (!(dif.fu_valid[0] && !m_acc[0])) set_fu(0, 1'b1, next_tag());
      if (!(dif.fu_valid[2] && !m_acc[2])) set_fu(2, 1'b1, next_tag());
      tick();
      if (m_acc[1] && bi < 3) begin
        bi++;
        if (bi < 3) set_fu(1, 1'b1, bp_tags[bi]);
        else dif.fu_valid[1] = 1'b0;
      end
    end
    dif.fu_valid = '0;
    repeat (6) tick();
    watch_fu1 = 1'b0;
    check_eq("bp_count", 64'(fu1_tags.size()), 64'd3);
    for (int j = 0; j < 3; j++)
      check_eq($sformatf("bp_order[%0d]", j), 64'((j < fu1_tags.size()) ? fu1_tags[j] : 8'h00), 64'(bp_tags[j]));

    // Flush with buffered results and a same-cycle enqueue
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, next_tag());
    tick();
    for (int i = 0; i < NFU; i++) if (m_acc[i]) set_fu(i, 1'b1, next_tag());
    tick();
    dif.fu_valid = '0;
    set_fu(0, 1'b1, 8'hEE);
    watch_ee = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dif.fu_valid = '0;
    check_eq("flush_valid", 64'(dif.cdb_valid), 64'd0);
    check_eq("flush_ready", 64'(dif.fu_ready), 64'(3'b111));
    repeat (5) tick();
    watch_ee = 1'b0;
    check_eq("flush_tag_seen", 64'(ee_seen), 64'd0);

    // Fairness: all FUs continuously valid
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < NFU; i++) grant_cnt[i] = 0;
    for (int c = 0; c < 33; c++) begin
      for (int i = 0; i < NFU; i++)
        if (!(dif.fu_valid[i] && !m_acc[i])) set_fu(i, 1'b1, next_tag());
      count_grants = (c >= 3);
      tick();
    end
    count_grants = 1'b0;
    for (int i = 0; i < NFU; i++)
      check_eq($sformatf("fair_grants[%0d]", i), 64'(grant_cnt[i]), 64'd20);

    // Single result from an empty FIFO: latency
    dif.fu_valid = '0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    set_fu(2, 1'b1, 8'h5A);
    tick();
    dif.fu_valid = '0;
`ifdef CDB_ARB_BYPASS_EN
    check_eq("byp_valid", 64'(dif.cdb_valid), 64'(2'b01));
    check_eq("byp_tag", 64'(dif.cdb_data[0].tag), 64'h5A);
    check_eq("byp_ready2", 64'(dif.fu_ready[2]), 64'd1);
`else
    check_eq("lat_e1_valid", 64'(dif.cdb_valid), 64'd0);
    tick();
    check_eq("lat_e2_valid", 64'(dif.cdb_valid), 64'(2'b01));
    check_eq("lat_e2_tag", 64'(dif.cdb_data[0].tag), 64'h5A);
`endif
    tick();

    // Randomized traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      rand_drive(60);
      flush = ($urandom_range(0, 39) == 0);
      tick();
      flush = 1'b0;
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, next_tag());
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(dif.cdb_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(dif.fu_ready), 64'(3'b111));
    check_eq("mid_rst_rr", 64'(dut.rr_ptr_r), 64'd0);
    for (int i = 0; i < NFU; i++) mq[i].delete();
    m_rr  = 0;
    m_acc = '0;
    dif.fu_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
